// File: rtl/dct_transpose_8x8.sv
// dct_transpose_8x8
// Ping-pong transpose buffer between the row-pass and column-pass 1-D DCTs.
// Rows arrive one per in_valid cycle. Each completed 8x8 block is emitted
// column by column, one column per cycle. Neither side has back-pressure.
module dct_transpose_8x8 #(
  parameter int W = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           in_sof,
  input  logic [8*W-1:0] in_row,
  output logic           out_valid,
  output logic [8*W-1:0] out_col,
  output logic [2:0]     out_idx,
  output logic           out_last,
  output logic           err_align
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } rd_state_t;

  // Two banks of eight rows. Address is {bank, row}. A whole column is read
  // at once, so the storage is a register array rather than a RAM.
  logic [8*W-1:0] mem [0:15];

  // Write-side state
  logic [2:0] wr_row_reg;
  logic       wr_bank_reg;
  logic [1:0] full_reg;
  logic [2:0] wr_idx;
  logic       fill_done;

  // Read-side state
  rd_state_t  state_reg, state_next;
  logic       rd_bank_reg, rd_bank_next;
  logic [2:0] rd_col_reg, rd_col_next;
  logic       drain_start;

  logic [8*W-1:0] col_data;

  // A qualified in_sof always restarts the block at row 0.
  assign wr_idx    = (in_valid && in_sof) ? 3'd0 : wr_row_reg;
  assign fill_done = in_valid && (wr_idx == 3'd7);

  // Row storage write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[{wr_bank_reg, wr_idx}] <= in_row;
    end
  end

  // Row counter, write bank toggle and sticky alignment error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_row_reg  <= 3'd0;
      wr_bank_reg <= 1'b0;
      err_align   <= 1'b0;
    end else if (in_valid) begin
      if (in_sof && (wr_row_reg != 3'd0)) begin
        err_align <= 1'b1;
      end
      if (wr_idx == 3'd7) begin
        wr_row_reg  <= 3'd0;
        wr_bank_reg <= ~wr_bank_reg;
      end else begin
        wr_row_reg  <= wr_idx + 3'd1;
      end
    end
  end

  // Per-bank FULL flag: set when row 7 lands, cleared when that bank's drain
  // starts. Starting a drain on the same edge as the fill wins over setting.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          full_reg[gi] <= 1'b0;
        end else if (drain_start && (rd_bank_next == 1'(gi))) begin
          full_reg[gi] <= 1'b0;
        end else if (fill_done && (wr_bank_reg == 1'(gi))) begin
          full_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      rd_bank_reg <= 1'b0;
      rd_col_reg  <= 3'd0;
    end else begin
      state_reg   <= state_next;
      rd_bank_reg <= rd_bank_next;
      rd_col_reg  <= rd_col_next;
    end
  end

  // Read FSM next state: start draining on the row-7 edge so column 0 is
  // registered one edge later; chain into the other bank without a gap.
  always_comb begin
    state_next   = state_reg;
    rd_bank_next = rd_bank_reg;
    rd_col_next  = rd_col_reg;
    drain_start  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (fill_done) begin
          drain_start  = 1'b1;
          state_next   = S_DRAIN;
          rd_bank_next = wr_bank_reg;
          rd_col_next  = 3'd0;
        end
      end
      S_DRAIN: begin
        if (rd_col_reg == 3'd7) begin
          rd_col_next = 3'd0;
          if (full_reg[~rd_bank_reg] ||
              (fill_done && (wr_bank_reg != rd_bank_reg))) begin
            drain_start  = 1'b1;
            rd_bank_next = ~rd_bank_reg;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          rd_col_next = rd_col_reg + 3'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Column gather: element r of the column is word rd_col of row r.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_col
      localparam logic [2:0] ROW = 3'(gi);
      logic [8*W-1:0] row_word;
      assign row_word = mem[{rd_bank_reg, ROW}];
      assign col_data[gi*W +: W] = row_word[rd_col_reg*W +: W];
    end
  endgenerate

  // Output register: one column per DRAIN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_col   <= '0;
      out_idx   <= 3'd0;
      out_last  <= 1'b0;
    end else if (state_reg == S_DRAIN) begin
      out_valid <= 1'b1;
      out_col   <= col_data;
      out_idx   <= rd_col_reg;
      out_last  <= (rd_col_reg == 3'd7);
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
